// File: rtl/hack_pkg.sv
// hack_pkg
//   Shared definitions for the Hack-style datapath: default widths, bit
//   positions of the dest/jump instruction fields and the writeback FSM
//   state encoding.
package hack_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_PC_WIDTH = 15;

  // dest field {A,D,M}
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  // jump field {lt,eq,gt}
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } wb_state_e;

endpackage : hack_pkg

// File: rtl/jump_cond.sv
// jump_cond
//   Purely combinational branch evaluator. Each set jump bit selects one of
//   the three mutually exclusive ALU outcomes (less than, equal, greater than
//   zero); the branch is taken if any selected outcome holds.
// Ports:
//   jump  [2:0]  {lt,eq,gt} condition mask
//   zr           ALU result is zero
//   ng           ALU result is negative
//   taken        branch condition true
module jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  assign taken = (jump[JMP_LT] & ng)
               | (jump[JMP_EQ] & zr)
               | (jump[JMP_GT] & ~zr & ~ng);

endmodule : jump_cond

// File: rtl/alu_writeback.sv
// alu_writeback
//   Retirement stage behind the Hack ALU. Owns the architectural A, D and PC
//   registers, resolves jumps, and issues data-memory writes for the M
//   destination over a valid/ready handshake. A-instructions (immediate loads
//   into A) retire here too.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    instruction handshake; ready only while IDLE
//   is_a_inst, imm         A-instruction flag and immediate
//   out, zr, ng            ALU result and flags
//   dest, jump             {A,D,M} write enables, {lt,eq,gt} jump mask
//   mem_we/addr/wdata      memory write request, held until mem_ready
//   mem_ready              memory accepts the write this cycle
//   a_reg, d_reg, pc       architectural state
//   retired                one-cycle pulse per completed instruction
module alu_writeback
  import hack_pkg::*;
#(
  parameter int                  WIDTH    = DEFAULT_WIDTH,
  parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_a_inst,
  input  logic [PC_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]    out,
  input  logic                zr,
  input  logic                ng,
  input  logic [2:0]          dest,
  input  logic [2:0]          jump,
  output logic                mem_we,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic                mem_ready,
  output logic [WIDTH-1:0]    a_reg,
  output logic [WIDTH-1:0]    d_reg,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retired
);

  wb_state_e            state_q,     state_d;
  logic [WIDTH-1:0]     a_q,         a_d;
  logic [WIDTH-1:0]     d_q,         d_d;
  logic [PC_WIDTH-1:0]  pc_q,        pc_d;
  logic                 mem_we_q,    mem_we_d;
  logic [PC_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                 retired_q,   retired_d;

  logic taken;

  jump_cond u_jump_cond (
    .jump  (jump),
    .zr    (zr),
    .ng    (ng),
    .taken (taken)
  );

  // Jump targets and write addresses come from the low bits of the A value
  // held before this instruction, even when the same instruction writes A.
  logic [PC_WIDTH-1:0] a_addr;
  logic [PC_WIDTH-1:0] pc_inc;

  assign a_addr = a_q[PC_WIDTH-1:0];
  assign pc_inc = pc_q + PC_WIDTH'(1);  // wraps modulo 2^PC_WIDTH

  always_comb begin
    // NOTE: every signal gets its hold/default value first so that no path
    // through the case/if tree leaves one unassigned and infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    d_d         = d_q;
    pc_d        = pc_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retired_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_a_inst) begin
            a_d       = WIDTH'(imm);
            pc_d      = pc_inc;
            retired_d = 1'b1;
          end else begin
            if (dest[DEST_D]) d_d = out;
            if (dest[DEST_A]) a_d = out;
            pc_d = taken ? a_addr : pc_inc;
            if (dest[DEST_M]) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = a_addr;
              mem_wdata_d = out;
              state_d     = ST_MEM_WAIT;
            end else begin
              retired_d = 1'b1;
            end
          end
        end
      end

      ST_MEM_WAIT: begin
        // Request is held untouched until the memory takes it.
        if (mem_ready) begin
          mem_we_d  = 1'b0;
          state_d   = ST_IDLE;
          retired_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: asynchronous reset clears the whole state, so a write stuck in
  // MEM_WAIT is abandoned with mem_we falling immediately and no retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      d_q         <= '0;
      pc_q        <= RESET_PC;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retired_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed in always_comb, independent of statement order.
      state_q     <= state_d;
      a_q         <= a_d;
      d_q         <= d_d;
      pc_q        <= pc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retired_q   <= retired_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign a_reg     = a_q;
  assign d_reg     = d_q;
  assign pc        = pc_q;
  assign retired   = retired_q;

endmodule : alu_writeback

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback
//   Directed and randomized checks of alu_writeback against an
//   instruction-level reference model of the architectural A/D/PC state.
module tb_alu_writeback;

  localparam int WIDTH    = 16;
  localparam int PC_WIDTH = 15;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                is_a_inst;
  logic [PC_WIDTH-1:0] imm;
  logic [WIDTH-1:0]    out;
  logic                zr;
  logic                ng;
  logic [2:0]          dest;
  logic [2:0]          jump;
  logic                mem_we;
  logic [PC_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic                mem_ready;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    d_reg;
  logic [PC_WIDTH-1:0] pc;
  logic                retired;

  alu_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_a_inst (is_a_inst),
    .imm       (imm),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .dest      (dest),
    .jump      (jump),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .a_reg     (a_reg),
    .d_reg     (d_reg),
    .pc        (pc),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference architectural state.
  logic [WIDTH-1:0]    m_a;
  logic [WIDTH-1:0]    m_d;
  logic [PC_WIDTH-1:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Jump semantics at the instruction level: the flags classify the result
  // as less-than, equal-to or greater-than zero; a jump mask bit selects each.
  function automatic bit model_taken(input logic [2:0] j, input logic z, input logic n);
    bit lt, eq, gt;
    lt = (n == 1'b1);
    eq = (z == 1'b1);
    gt = !lt && !eq;
    return (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
  endfunction

  task automatic scramble_inputs();
    is_a_inst = 1'($urandom);
    imm       = PC_WIDTH'($urandom);
    out       = WIDTH'($urandom);
    zr        = 1'($urandom);
    ng        = 1'($urandom);
    dest      = 3'($urandom);
    jump      = 3'($urandom);
  endtask

  task automatic check_arch(input string tag);
    check({tag, ".a"},  32'(a_reg), 32'(m_a));
    check({tag, ".d"},  32'(d_reg), 32'(m_d));
    check({tag, ".pc"}, 32'(pc),    32'(m_pc));
  endtask

  // Issue one instruction, update the model, check the result; for an M
  // write, stall the memory for wait_cycles cycles with in_valid held high.
  task automatic do_inst(input string tag, input logic ia, input logic [PC_WIDTH-1:0] im,
                         input logic [WIDTH-1:0] o, input logic z, input logic n,
                         input logic [2:0] de, input logic [2:0] ju, input int wait_cycles);
    logic [WIDTH-1:0] old_a;
    bit               is_m;
    is_a_inst = ia; imm = im; out = o; zr = z; ng = n; dest = de; jump = ju;
    mem_ready = 1'($urandom);   // ignored while no write is pending
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    scramble_inputs();

    old_a = m_a;
    is_m  = 1'b0;
    if (ia) begin
      m_a  = WIDTH'(im);
      m_pc = m_pc + 1'b1;
    end else begin
      if (de[1]) m_d = o;
      if (de[2]) m_a = o;
      m_pc = model_taken(ju, z, n) ? old_a[PC_WIDTH-1:0] : m_pc + 1'b1;
      is_m = de[0];
    end
    check_arch(tag);

    if (!is_m) begin
      check({tag, ".retired"},  32'(retired),  32'd1);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".mem_we"},   32'(mem_we),   32'd0);
    end else begin
      check({tag, ".retired"},  32'(retired),  32'd0);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".mem_we"},   32'(mem_we),   32'd1);
      check({tag, ".addr"},     32'(mem_addr), 32'(old_a[PC_WIDTH-1:0]));
      check({tag, ".wdata"},    32'(mem_wdata), 32'(o));
      for (int k = 0; k < wait_cycles; k++) begin
        in_valid = 1'b1;        // must not be accepted while waiting
        tick();
        scramble_inputs();
        check({tag, ".wait_we"},    32'(mem_we),    32'd1);
        check({tag, ".wait_addr"},  32'(mem_addr),  32'(old_a[PC_WIDTH-1:0]));
        check({tag, ".wait_wdata"}, 32'(mem_wdata), 32'(o));
        check({tag, ".wait_ready"}, 32'(in_ready),  32'd0);
        check({tag, ".wait_ret"},   32'(retired),   32'd0);
        check_arch({tag, ".wait"});
      end
      in_valid  = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check({tag, ".done_we"},    32'(mem_we),   32'd0);
      check({tag, ".done_ret"},   32'(retired),  32'd1);
      check({tag, ".done_ready"}, 32'(in_ready), 32'd1);
      check_arch({tag, ".done"});
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    scramble_inputs();

    // Reset asserted mid-cycle: outputs must clear with no clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst.a",        32'(a_reg),    32'd0);
    check("rst.d",        32'(d_reg),    32'd0);
    check("rst.pc",       32'(pc),       32'd0);
    check("rst.mem_we",   32'(mem_we),   32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.retired",  32'(retired),  32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rst.ret_after", 32'(retired), 32'd0);
    tick();
    check("rst.ret_after2", 32'(retired), 32'd0);
    m_a = '0; m_d = '0; m_pc = '0;

    // A then C back to back: two consecutive retire pulses.
    do_inst("a_1234",  1'b1, 15'h1234, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    do_inst("c_dload", 1'b0, 15'h0000, 16'h00FF, 1'b0, 1'b0, 3'b010, 3'b000, 0);
    tick();
    check("idle.retired_drop", 32'(retired), 32'd0);

    // Jumps with A = 0x0010.
    do_inst("a_0010",  1'b1, 15'h0010, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    do_inst("jlt",     1'b0, 15'h0000, 16'hFFFF, 1'b0, 1'b1, 3'b000, 3'b100, 0);
    do_inst("jgt_no",  1'b0, 15'h0000, 16'hFFFF, 1'b0, 1'b1, 3'b000, 3'b001, 0);
    do_inst("jeq",     1'b0, 15'h0000, 16'h0000, 1'b1, 1'b0, 3'b000, 3'b010, 0);
    do_inst("jmp",     1'b0, 15'h0000, 16'h1234, 1'b0, 1'b0, 3'b000, 3'b111, 0);
    do_inst("jnull",   1'b0, 15'h0000, 16'h0000, 1'b1, 1'b0, 3'b000, 3'b000, 0);
    // dest=A with a taken jump: target is the old A.
    do_inst("a_jmp",   1'b0, 15'h0000, 16'h0099, 1'b0, 1'b0, 3'b100, 3'b111, 0);

    // M write with A|M, memory stalled for three cycles.
    do_inst("a_0020",  1'b1, 15'h0020, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    do_inst("am_wr",   1'b0, 15'h0000, 16'h0055, 1'b0, 1'b0, 3'b101, 3'b000, 3);
    // Minimum-latency M write.
    do_inst("m_fast",  1'b0, 15'h0000, 16'hBEEF, 1'b0, 1'b1, 3'b001, 3'b000, 0);

    // PC wrap.
    do_inst("a_7fff",  1'b1, 15'h7FFF, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    do_inst("j_7fff",  1'b0, 15'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b111, 0);
    do_inst("wrap",    1'b0, 15'h0000, 16'h0001, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    check("wrap.pc_zero", 32'(pc), 32'd0);

    // Reset while a write is pending.
    do_inst("a_0030",  1'b1, 15'h0030, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);
    is_a_inst = 1'b0; out = 16'hABCD; zr = 1'b0; ng = 1'b0; dest = 3'b001; jump = 3'b000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rstw.mem_we_set", 32'(mem_we), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstw.mem_we",   32'(mem_we),   32'd0);
    check("rstw.in_ready", 32'(in_ready), 32'd1);
    check("rstw.pc",       32'(pc),       32'd0);
    check("rstw.retired",  32'(retired),  32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("rstw.no_retire", 32'(retired), 32'd0);
    m_a = '0; m_d = '0; m_pc = '0;
    do_inst("post_rst", 1'b1, 15'h0042, 16'h0000, 1'b0, 1'b0, 3'b000, 3'b000, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      do_inst($sformatf("rnd%0d", i), 1'($urandom), PC_WIDTH'($urandom), WIDTH'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_writeback

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Downstream stage of the 16-bit Hack-style ALU. It takes the ALU result and its zr/ng flags together with the instruction's dest and jump fields. It owns the architectural A, D and PC registers, evaluates the jump condition, and performs data-memory writes (M destination) over a valid/ready handshake. A-instructions (immediate loads into A) also retire through this block.

Parameters:
WIDTH, 16, datapath width; must match ALU x/y/out width
PC_WIDTH, 15, program counter and memory address width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  instruction slot valid
in_ready  output  1  block can accept; high exactly when FSM is IDLE
is_a_inst  input  1  1 = A-instruction (load imm); 0 = C-instruction
imm  input  PC_WIDTH  A-instruction immediate
out  input  WIDTH  ALU result
zr  input  1  ALU zero flag
ng  input  1  ALU negative flag
dest  input  3  {A,D,M} write enables, bit2=A, bit1=D, bit0=M
jump  input  3  {lt,eq,gt}, bit2=lt, bit1=eq, bit0=gt
mem_we  output  1  memory write request
mem_addr  output  PC_WIDTH  write address
mem_wdata  output  WIDTH  write data
mem_ready  input  1  memory accepts write this cycle
a_reg  output  WIDTH  A register, feeds ALU y / address
d_reg  output  WIDTH  D register, feeds ALU x
pc  output  PC_WIDTH  program counter
retired  output  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (async, rst_n=0): a_reg=0, d_reg=0, pc=RESET_PC, mem_we=0, mem_addr=0, mem_wdata=0, retired=0, FSM=IDLE. Outputs change immediately, not at the next edge.
- FSM states: IDLE and MEM_WAIT. in_ready = (state==IDLE), combinational.
- Accept: in_valid & in_ready at a rising edge. Inputs is_a_inst, imm, out, zr, ng, dest and jump are sampled only at accept; they are don't-care otherwise.
- A-instruction at accept:
  - a_reg <= zero-extended imm; pc <= pc+1.
  - dest and jump are ignored.
  - retired=1 in the following cycle; state stays IDLE.
- C-instruction, taken = (jump[2]&ng) | (jump[1]&zr) | (jump[0]&~zr&~ng).
  - jump=111 is unconditional; jump=000 never jumps.
- C-instruction register updates, all at the accept edge, all using the pre-accept value of a_reg:
  - dest[1]: d_reg <= out.
  - dest[2]: a_reg <= out.
  - taken: pc <= old a_reg[PC_WIDTH-1:0]; otherwise pc <= pc+1.
- C-instruction without dest[0]: retired=1 next cycle; state stays IDLE.
- C-instruction with dest[0] (M write):
  - At accept: mem_addr <= old a_reg[PC_WIDTH-1:0], mem_wdata <= out, mem_we <= 1; go to MEM_WAIT.
  - In MEM_WAIT, mem_we, mem_addr and mem_wdata are held stable until mem_ready=1 is sampled.
  - At that edge: mem_we <= 0, state <= IDLE, retired <= 1.
  - Minimum M-write latency: 2 cycles from accept to in_ready high again.
- mem_ready is ignored while mem_we=0.
- retired is high for exactly one cycle per instruction. Back-to-back non-M instructions give back-to-back retired pulses, with throughput 1 instruction/cycle.
- PC wraps modulo 2^PC_WIDTH: 0x7FFF+1 = 0x0000.
- dest=A|M: the memory address is the old A; A takes out. dest=A with a taken jump: the jump target is the old A.
- Reset in MEM_WAIT: the write is abandoned, mem_we drops asynchronously, state=IDLE, and no retired pulse is issued.

Decomposition:
- Package hack_pkg holds:
  - WIDTH and PC_WIDTH defaults.
  - Dest bit indices: DEST_A=2, DEST_D=1, DEST_M=0.
  - Jump bit indices: JMP_LT=2, JMP_EQ=1, JMP_GT=0.
  - FSM state encoding: ST_IDLE, ST_MEM_WAIT.
- One natural sub-module: jump_cond, a purely combinational block (jump[2:0], zr, ng -> taken). It is reused later by fetch/branch logic.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> immediately a_reg=0, d_reg=0, pc=0, mem_we=0, in_ready=1; retired stays 0 after release.
- A-inst imm=0x1234 at pc=0 -> next cycle a_reg=0x1234, pc=1, retired=1. Then C-inst out=0x00FF, dest=010, jump=000 -> d_reg=0x00FF, pc=2, with back-to-back retired pulses.
- Jumps with a_reg=0x0010:
  - out=0xFFFF, ng=1, zr=0, jump=100 -> pc=0x0010.
  - Same inputs with jump=001 -> pc=old pc+1.
  - zr=1, jump=010 -> pc=0x0010.
  - jump=111 with any flags -> pc=0x0010.
- M write: a_reg=0x0020, out=0x0055, dest=101. Hold mem_ready=0 for 3 cycles, then 1.
  - While waiting: mem_we=1, mem_addr=0x0020, mem_wdata=0x0055 stable; in_ready=0; a_reg=0x0055.
  - After mem_ready: mem_we=0, retired=1 for one cycle, in_ready=1.
- Wrap and ignored-input checks: pc=0x7FFF with non-jumping C-inst -> pc=0x0000. in_valid=1 while in MEM_WAIT -> instruction not accepted and no register change.
- Reset during MEM_WAIT -> mem_we=0 without a clock edge, state IDLE, no retired pulse; the next accepted instruction behaves normally.
